// File: rtl/velocity_write_scheduler.sv
// velocity_write_scheduler
// Snapshots the six bot velocity words on update_req, waits a settle window,
// then hands the shared velocity write channel to bots 1..3 in round-robin
// order (only to bots whose peer is ready), and pulses done at round end.
// Optional feature macro: WRITE_TIMEOUT_EN. When defined, a bot that stays
// not-ready for TIMEOUT_CYCLES after the last grant is dropped and flagged
// in skipped. When undefined, arbitration waits indefinitely and skipped is 0.
module velocity_write_scheduler #(
    parameter int DATA_W         = 16,
    parameter int SETTLE_CYCLES  = 300,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              update_req,
    input  logic [DATA_W-1:0] vx1_bin,
    input  logic [DATA_W-1:0] vy1_bin,
    input  logic [DATA_W-1:0] vx2_bin,
    input  logic [DATA_W-1:0] vy2_bin,
    input  logic [DATA_W-1:0] vx3_bin,
    input  logic [DATA_W-1:0] vy3_bin,
    input  logic [2:0]        bot_ready,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [1:0]        wr_bot_id,
    output logic [DATA_W-1:0] wr_vx,
    output logic [DATA_W-1:0] wr_vy,
    output logic              busy,
    output logic [2:0]        pending,
    output logic              done,
    output logic              overrun,
    output logic [2:0]        skipped
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        ARB    = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // The settle counter runs through 0..SETTLE_CYCLES inclusive, so ARB is
    // entered SETTLE_CYCLES+1 cycles after the edge that accepted update_req.
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);
`ifdef WRITE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    state_t            state;
    logic [CNT_W-1:0]  counter;
    logic [1:0]        rr_idx;      // 0-based index of the bot searched first
    logic [1:0]        cur_idx;     // 0-based index of the bot being written
    logic [DATA_W-1:0] snap_vx [3];
    logic [DATA_W-1:0] snap_vy [3];
    logic [DATA_W-1:0] in_vx   [3];
    logic [DATA_W-1:0] in_vy   [3];
    logic [2:0]        eligible;
    logic              pick_found;
    logic [1:0]        pick_idx;
    logic [1:0]        cand;

    assign in_vx[0] = vx1_bin;
    assign in_vy[0] = vy1_bin;
    assign in_vx[1] = vx2_bin;
    assign in_vy[1] = vy2_bin;
    assign in_vx[2] = vx3_bin;
    assign in_vy[2] = vy3_bin;

    assign eligible = pending & bot_ready;

    // Modulo-3 advance of a 0-based bot index.
    function automatic logic [1:0] wrap3(input logic [1:0] base, input logic [1:0] step);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

    // Round-robin pick: scan from the farthest candidate back to rr_idx so
    // the candidate closest to the pointer is the one left standing.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        cand       = 2'd0;
        for (int off = 2; off >= 0; off--) begin
            cand = wrap3(rr_idx, off[1:0]);
            if (eligible[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Round sequencer: all outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            counter   <= '0;
            rr_idx    <= 2'd0;
            cur_idx   <= 2'd0;
            wr_valid  <= 1'b0;
            wr_bot_id <= 2'd0;
            wr_vx     <= '0;
            wr_vy     <= '0;
            busy      <= 1'b0;
            pending   <= 3'b000;
            done      <= 1'b0;
            overrun   <= 1'b0;
`ifdef WRITE_TIMEOUT_EN
            skipped   <= 3'b000;
`endif
            for (int i = 0; i < 3; i++) begin
                snap_vx[i] <= '0;
                snap_vy[i] <= '0;
            end
        end else begin
            done    <= 1'b0;
            // Any request outside IDLE (DONE included) is dropped and flagged.
            overrun <= update_req && (state != IDLE);
            case (state)
                IDLE: begin
                    if (update_req) begin
                        for (int i = 0; i < 3; i++) begin
                            snap_vx[i] <= in_vx[i];
                            snap_vy[i] <= in_vy[i];
                        end
                        pending <= 3'b111;
`ifdef WRITE_TIMEOUT_EN
                        skipped <= 3'b000;
`endif
                        counter <= '0;
                        busy    <= 1'b1;
                        state   <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (counter == SETTLE_LAST) begin
                        counter <= '0;
                        state   <= ARB;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                ARB: begin
                    if (pending == 3'b000) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else if (pick_found) begin
                        cur_idx   <= pick_idx;
                        wr_bot_id <= pick_idx + 2'd1;
                        wr_vx     <= snap_vx[pick_idx];
                        wr_vy     <= snap_vy[pick_idx];
                        wr_valid  <= 1'b1;
                        state     <= WRITE;
                    end
`ifdef WRITE_TIMEOUT_EN
                    else if (counter == TIMEOUT_LAST) begin
                        // Give up on every bot still outstanding.
                        skipped <= pending;
                        pending <= 3'b000;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end else begin
                        counter <= counter + 1'b1;
                    end
`endif
                end
                WRITE: begin
                    // bot_ready is not looked at here: once offered, the word stays.
                    if (wr_ready) begin
                        pending[cur_idx] <= 1'b0;
                        rr_idx           <= wrap3(cur_idx, 2'd1);
                        wr_valid         <= 1'b0;
                        counter          <= '0;
                        state            <= ARB;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef WRITE_TIMEOUT_EN
    assign skipped = 3'b000;
`endif

endmodule

// File: tb/tb_velocity_write_scheduler.sv
// Self-checking bench for velocity_write_scheduler: table of update rounds
// plus directed sequences for stall, late-ready, overrun and reset corners.
module tb_velocity_write_scheduler;

    localparam int DATA_W  = 16;
    localparam int SETTLE  = 300;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              update_req = 1'b0;
    logic [DATA_W-1:0] vx1_bin = '0, vy1_bin = '0, vx2_bin = '0;
    logic [DATA_W-1:0] vy2_bin = '0, vx3_bin = '0, vy3_bin = '0;
    logic [2:0]        bot_ready = 3'b111;
    logic              wr_ready = 1'b1;
    logic              wr_valid;
    logic [1:0]        wr_bot_id;
    logic [DATA_W-1:0] wr_vx, wr_vy;
    logic              busy, done, overrun;
    logic [2:0]        pending, skipped;

    velocity_write_scheduler #(
        .DATA_W(DATA_W), .SETTLE_CYCLES(SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .update_req(update_req),
        .vx1_bin(vx1_bin), .vy1_bin(vy1_bin), .vx2_bin(vx2_bin),
        .vy2_bin(vy2_bin), .vx3_bin(vx3_bin), .vy3_bin(vy3_bin),
        .bot_ready(bot_ready), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_bot_id(wr_bot_id), .wr_vx(wr_vx), .wr_vy(wr_vy),
        .busy(busy), .pending(pending), .done(done),
        .overrun(overrun), .skipped(skipped)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0][15:0] vx;
        logic [2:0][15:0] vy;
        logic [2:0][1:0]  order;   // expected bot id of write 0,1,2
    } vec_t;

    vec_t tbl [4];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic vec_t mk(input logic [15:0] x1, input logic [15:0] y1,
                                input logic [15:0] x2, input logic [15:0] y2,
                                input logic [15:0] x3, input logic [15:0] y3,
                                input logic [1:0] o0, input logic [1:0] o1,
                                input logic [1:0] o2);
        vec_t v;
        v.vx[0] = x1; v.vy[0] = y1;
        v.vx[1] = x2; v.vy[1] = y2;
        v.vx[2] = x3; v.vy[2] = y3;
        v.order[0] = o0; v.order[1] = o1; v.order[2] = o2;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input vec_t v);
        vx1_bin = v.vx[0]; vy1_bin = v.vy[0];
        vx2_bin = v.vx[1]; vy2_bin = v.vy[1];
        vx3_bin = v.vx[2]; vy3_bin = v.vy[2];
    endtask

    task automatic start_round(input vec_t v);
        set_inputs(v);
        update_req = 1'b1;
        tick();
        update_req = 1'b0;
    endtask

    // Advance until wr_valid is seen; an expired bound counts as a failure.
    task automatic wait_valid(input string tag, output int cycles);
        cycles = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            cycles++;
            if (wr_valid) return;
        end
        n_total++;
        $display("FAIL %s: wr_valid never asserted within 1000 cycles", tag);
    endtask

    // Wait for the next offered word, compare it to the snapshot of bot b,
    // then clock the edge on which it is accepted (wr_ready assumed 1).
    task automatic expect_write(input string tag, input vec_t v, input int b, output int lat);
        wait_valid(tag, lat);
        check({tag, ".bot_id"}, 64'(wr_bot_id), 64'(b));
        check({tag, ".vx"}, 64'(wr_vx), 64'(v.vx[b-1]));
        check({tag, ".vy"}, 64'(wr_vy), 64'(v.vy[b-1]));
        $display("write %s: bot=%0d vx=0x%04h vy=0x%04h after %0d cycles",
                 tag, wr_bot_id, wr_vx, wr_vy, lat);
        tick();
    endtask

    // Called right after the last accept edge.
    task automatic expect_done(input string tag);
        check({tag, ".done_pre"}, 64'(done), 64'd0);
        tick();
        check({tag, ".done"}, 64'({done, busy, pending}), 64'({1'b1, 1'b0, 3'b000}));
        tick();
        check({tag, ".done_post"}, 64'(done), 64'd0);
        $display("round %s: done observed", tag);
    endtask

    initial begin
        int   lat;
        vec_t va, vb;

        tbl[0] = mk(16'h0800, 16'h0400, 16'h1000, 16'h0001, 16'h7FFF, 16'h0C00, 2'd1, 2'd2, 2'd3);
        tbl[1] = mk(16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h8000, 16'h0001, 2'd1, 2'd2, 2'd3);
        tbl[2] = mk(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F, 16'hF0F0, 2'd1, 2'd2, 2'd3);
        tbl[3] = mk(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 2'd1, 2'd2, 2'd3);

        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        check("reset.flags", 64'({wr_valid, busy, done, overrun}), 64'd0);
        check("reset.pending_skipped", 64'({pending, skipped}), 64'd0);
        check("reset.wr_data", 64'({wr_bot_id, wr_vx, wr_vy}), 64'd0);
        $display("reset: wr_valid=%0b busy=%0b pending=%03b", wr_valid, busy, pending);
        rst_n = 1'b1;
        tick();

        // Table rounds: all bots ready, writer always ready, order 1,2,3
        for (int r = 0; r < 4; r++) begin
            string tag;
            tag = $sformatf("tbl%0d", r);
            start_round(tbl[r]);
            check({tag, ".busy"}, 64'(busy), 64'd1);
            for (int w = 0; w < 3; w++) begin
                expect_write($sformatf("%s.w%0d", tag, w), tbl[r], int'(tbl[r].order[w]), lat);
                if (w == 0) check({tag, ".latency"}, 64'(lat), 64'(SETTLE + 2));
            end
            expect_done(tag);
        end

        // Bot 2 late: writes 1, 3, then 2 once it becomes ready
        va = mk(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 2'd1, 2'd3, 2'd2);
        bot_ready = 3'b101;
        start_round(va);
        expect_write("late.w0", va, 1, lat);
        expect_write("late.w1", va, 3, lat);
        for (int i = 0; i < 50; i++) tick();
        check("late.idle_valid", 64'(wr_valid), 64'd0);
        check("late.pending", 64'(pending), 64'(3'b010));
        bot_ready = 3'b111;
        expect_write("late.w2", va, 2, lat);
        expect_done("late");

        // Writer stall: outputs must hold for 20 cycles; pointer now at bot 3
        vb = mk(16'hAAAA, 16'h5555, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 2'd3, 2'd1, 2'd2);
        wr_ready = 1'b0;
        start_round(vb);
        wait_valid("stall", lat);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("stall.hold%0d", i), 64'({wr_valid, wr_bot_id, wr_vx, wr_vy}),
                  64'({1'b1, 2'd3, 16'h3333, 16'h4444}));
            tick();
        end
        $display("stall: held bot=%0d for 20 cycles", wr_bot_id);
        wr_ready = 1'b1;
        tick();
        expect_write("stall.w1", vb, 1, lat);
        expect_write("stall.w2", vb, 2, lat);
        expect_done("stall");

        // Overrun: second request during SETTLE is dropped, first snapshot kept
        va = mk(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 16'h0E0E, 16'h0F0F, 2'd3, 2'd1, 2'd2);
        vb = mk(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 16'hFACE, 16'hB00C, 2'd3, 2'd1, 2'd2);
        start_round(va);
        for (int i = 0; i < 5; i++) tick();
        set_inputs(vb);
        update_req = 1'b1;
        tick();
        update_req = 1'b0;
        check("ovr.pulse", 64'(overrun), 64'd1);
        tick();
        check("ovr.pulse_end", 64'(overrun), 64'd0);
        $display("overrun: pulse seen for dropped request");
        expect_write("ovr.w0", va, 3, lat);
        expect_write("ovr.w1", va, 1, lat);
        expect_write("ovr.w2", va, 2, lat);
        expect_done("ovr");

        // Reset in the middle of a WRITE aborts the round without done
        wr_ready = 1'b0;
        start_round(tbl[0]);
        wait_valid("rst", lat);
        rst_n = 1'b0;
        tick();
        check("rst.abort", 64'({wr_valid, busy, pending}), 64'd0);
        rst_n = 1'b1;
        wr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("rst.no_done%0d", i), 64'({done, busy}), 64'd0);
        end
        $display("reset mid-write: round aborted");

`ifdef WRITE_TIMEOUT_EN
        // Bot 3 never ready: 1 and 2 written, then timeout drops bot 3
        bot_ready = 3'b011;
        start_round(tbl[2]);
        expect_write("tmo.w0", tbl[2], 1, lat);
        expect_write("tmo.w1", tbl[2], 2, lat);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            lat++;
            if (done) break;
        end
        check("tmo.done_delay", 64'(lat), 64'(TIMEOUT));
        check("tmo.skipped", 64'({skipped, pending}), 64'({3'b100, 3'b000}));
        $display("timeout: done after %0d cycles, skipped=%03b", lat, skipped);
        bot_ready = 3'b111;
`else
        // Pointer back at bot 1 after reset; skipped stays clear
        start_round(tbl[3]);
        for (int w = 0; w < 3; w++) begin
            expect_write($sformatf("post.w%0d", w), tbl[3], w + 1, lat);
        end
        check("post.skipped", 64'(skipped), 64'd0);
        expect_done("post");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
